// File: rtl/display_scan_7seg_if.sv
// Signal bundle between the 4-digit 7-segment scanner, its upstream segment mux and the display.
// The slave modport is the scanner's view. The master modport is the environment's view.
interface display_scan_7seg_if;
    logic       enable;
    logic [3:0] digit_mask;
    logic [6:0] seg_in;
    logic [1:0] sel;
    logic [6:0] seg_out;
    logic [3:0] an;
    logic       frame_tick;

    modport slave (
        input  enable,
        input  digit_mask,
        input  seg_in,
        output sel,
        output seg_out,
        output an,
        output frame_tick
    );

    modport master (
        output enable,
        output digit_mask,
        output seg_in,
        input  sel,
        input  seg_out,
        input  an,
        input  frame_tick
    );
endinterface

// File: rtl/display_scan_7seg.sv
// Time-multiplexed 4-digit 7-segment scanner.
// Each slot steers the external mux, blanks while the mux settles, captures the pattern, then lights one anode.
module display_scan_7seg #(
    parameter int unsigned DIV           = 50000,
    parameter int unsigned BLANK         = 16,
    parameter logic [6:0]  SEG_OFF       = 7'b1111111,
    parameter bit          AN_ACTIVE_LOW = 1'b1
) (
    input  logic                clk,
    input  logic                rst_n,
    display_scan_7seg_if.slave  bus
);
    localparam int unsigned    CW          = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0]  CNT_LAST    = CW'(DIV - 1);
    localparam logic [CW-1:0]  CNT_CAPTURE = CW'(BLANK - 1);
    localparam logic [CW-1:0]  CNT_SHOW    = CW'(BLANK);

    logic [CW-1:0] cnt;
    logic [1:0]    sel;
    logic [6:0]    seg_reg;
    logic [3:0]    mask_reg;
    logic          frame_tick;

    logic          slot_end;
    logic          lit;
    logic [3:0]    an_hot;
    logic [6:0]    seg_out;

    assign slot_end = (cnt == CNT_LAST);

    // NOTE: non-blocking assignments, so every register below sees the pre-edge cnt/sel.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt        <= '0;
            sel        <= 2'd0;
            seg_reg    <= SEG_OFF;
            mask_reg   <= 4'b0000;
            frame_tick <= 1'b0;
        end else if (!bus.enable) begin
            // Holding cnt at 0 keeps the display blanked and restarts this slot on re-enable.
            cnt        <= '0;
            frame_tick <= 1'b0;
        end else begin
            frame_tick <= slot_end && (sel == 2'd3);
            if (cnt == CNT_CAPTURE) begin
                seg_reg  <= bus.seg_in;
                mask_reg <= bus.digit_mask;
            end
            if (slot_end) begin
                cnt <= '0;
                sel <= sel + 2'd1;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    // NOTE: every signal gets a default first, so no path can infer a latch.
    always_comb begin
        an_hot  = 4'b0000;
        seg_out = SEG_OFF;
        lit     = (cnt >= CNT_SHOW) && mask_reg[sel];
        if (lit) begin
            an_hot[sel] = 1'b1;
            seg_out     = seg_reg;
        end
    end

    assign bus.an         = AN_ACTIVE_LOW ? ~an_hot : an_hot;
    assign bus.seg_out    = seg_out;
    assign bus.sel        = sel;
    assign bus.frame_tick = frame_tick;
endmodule

// File: tb/tb_display_scan_7seg.sv
// Self-checking bench for display_scan_7seg: directed test-plan steps followed by a randomized run,
// checked every cycle against a slot-timeline reference model.
module tb_display_scan_7seg;
    localparam int DIV   = 8;
    localparam int BLANK = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    display_scan_7seg_if bus();

    // Segment mux model: the DUT's own selector picks one of four digit patterns.
    logic [6:0] dmem [4];
    assign bus.seg_in = dmem[bus.sel];

    display_scan_7seg #(
        .DIV(DIV), .BLANK(BLANK), .SEG_OFF(7'h7F), .AN_ACTIVE_LOW(1'b1)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    // Reference: position inside the current slot timeline, and what was latched for it.
    int         slot_age;
    int         slot_digit;
    logic [6:0] shown;
    logic [3:0] allowed;
    bit         tick_exp;
    int         vectors     = 0;
    int         miscompares = 0;

    task automatic model_edge();
        if (!rst_n) begin
            slot_age = 0; slot_digit = 0; shown = 7'h7F; allowed = 4'h0; tick_exp = 1'b0;
        end else if (!bus.enable) begin
            slot_age = 0; tick_exp = 1'b0;
        end else begin
            tick_exp = (slot_age == DIV - 1) && (slot_digit == 3);
            if (slot_age == BLANK - 1) begin
                shown   = dmem[slot_digit];
                allowed = bus.digit_mask;
            end
            slot_age = slot_age + 1;
            if (slot_age == DIV) begin
                slot_age   = 0;
                slot_digit = (slot_digit + 1) % 4;
            end
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        bit         lit;
        logic [3:0] exp_an;
        logic [6:0] exp_seg;
        @(posedge clk);
        model_edge();
        #1;
        lit     = (slot_age >= BLANK) && allowed[slot_digit];
        exp_an  = lit ? ~(4'b0001 << slot_digit) : 4'hF;
        exp_seg = lit ? shown : 7'h7F;
        check("sel",        32'(bus.sel),        32'(slot_digit));
        check("an",         32'(bus.an),         32'(exp_an));
        check("seg_out",    32'(bus.seg_out),    32'(exp_seg));
        check("frame_tick", 32'(bus.frame_tick), 32'(tick_exp));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    // Advance until the model reaches the requested slot position, with a cycle budget.
    task automatic wait_for(input int digit, input int age, input string tag);
        bit found = 1'b0;
        for (int i = 0; i < 4 * DIV + 2 && !found; i++) begin
            if (slot_digit == digit && slot_age == age) found = 1'b1;
            else cycle();
        end
        check(tag, 32'(found), 32'd1);
    endtask

    initial begin
        int first_tick;
        dmem[0] = 7'h01; dmem[1] = 7'h02; dmem[2] = 7'h04; dmem[3] = 7'h08;
        bus.enable     = 1'b1;
        bus.digit_mask = 4'hF;
        rst_n          = 1'b0;
        slot_age = 0; slot_digit = 0; shown = 7'h7F; allowed = 4'h0; tick_exp = 1'b0;

        // Reset held for three edges
        run(3);

        // Normal scan: first frame tick lands 32 edges after release
        rst_n      = 1'b1;
        first_tick = -1;
        for (int i = 1; i <= 72; i++) begin
            cycle();
            if (bus.frame_tick === 1'b1 && first_tick < 0) first_tick = i;
        end
        check("first_tick_cycle", 32'(first_tick), 32'd32);

        // Masking: only digits 0 and 2 may light
        bus.digit_mask = 4'b0101;
        run(40);
        bus.digit_mask = 4'hF;
        run(8);

        // Enable drop mid-show on digit 2, held low for ten edges
        wait_for(2, 5, "reach_sel2_cnt5");
        bus.enable = 1'b0;
        cycle();
        check("drop_an",  32'(bus.an),  32'h0000_000F);
        check("drop_sel", 32'(bus.sel), 32'd2);
        run(9);
        bus.enable = 1'b1;
        run(2);
        cycle();
        check("reenable_an",  32'(bus.an),      32'h0000_000B);
        check("reenable_seg", 32'(bus.seg_out), 32'h0000_0004);
        run(40);

        // Pattern change during digit-1 show stays invisible until the next digit-1 slot
        wait_for(1, BLANK + 1, "reach_digit1_show");
        dmem[1] = 7'h7E;
        run(40);

        // Reset asserted during a show phase
        wait_for(3, BLANK + 2, "reach_digit3_show");
        rst_n = 1'b0;
        cycle();
        check("midrst_an",  32'(bus.an),      32'h0000_000F);
        check("midrst_seg", 32'(bus.seg_out), 32'h0000_007F);
        rst_n = 1'b1;
        run(20);

        // Randomized run: pattern, mask, enable and occasional reset disturbances
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(7) == 0)   dmem[$urandom_range(3)] = 7'($urandom);
            if ($urandom_range(15) == 0)  bus.digit_mask = 4'($urandom);
            bus.enable = ($urandom_range(19) != 0);
            rst_n      = ($urandom_range(299) != 0);
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/display_scan_7seg.md
Name: display_scan_7seg

Overview:
- Time-multiplexed scanner for a 4-digit 7-segment display.
- Sits directly downstream of the 7-bit 4:1 segment mux and drives that mux's 2-bit selector.
- Each slot: drives `sel`, waits for the mux output to settle through a blanking window, captures the 7-bit pattern, then lights the matching digit anode.
- Produces a one-cycle frame tick each time a full 4-digit scan completes.

Parameters:
- DIV, 50000, clock cycles per digit slot (blank + show); must be >= BLANK+2.
- BLANK, 16, cycles at the start of each slot with all anodes off (anti-ghosting); must be >= 1.
- SEG_OFF, 7'b1111111, segment pattern driven while blanked or disabled.
- AN_ACTIVE_LOW, 1, 1 = anodes active-low, 0 = active-high.

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  synchronous active-low reset
- enable  in  1  scan enable; low forces blanking and restarts the current slot
- digit_mask  in  4  per-digit enable, bit i = digit i may light
- seg_in  in  7  segment pattern from the 4:1 segment mux output
- sel  out  2  digit index to the 4:1 segment mux selector
- seg_out  out  7  segment lines to the display
- an  out  4  digit anodes, one-hot active level per AN_ACTIVE_LOW
- frame_tick  out  1  one-cycle pulse at end of digit-3 slot

Behaviour:
- Clock and reset: one clock `clk`. Reset `rst_n` is synchronous, active-low.
- Registers:
  - `cnt` (`$clog2(DIV)` bits, 0..DIV-1)
  - `sel` (2 bits)
  - `seg_reg` (7 bits)
  - `mask_reg` (4 bits)
  - `frame_tick` (1 bit)
- Reset, sampled at a rising edge with `rst_n`=0:
  - `cnt`=0, `sel`=0, `seg_reg`=SEG_OFF, `mask_reg`=0, `frame_tick`=0.
  - Therefore `an`=all inactive (4'b1111 when active-low) and `seg_out`=SEG_OFF.
  - `rst_n` has priority over `enable`. Reset mid-slot discards the scan position.
- Outputs are decoded from registers only. There is no combinational path from any input to `an`, `seg_out` or `sel`.
- `sel` drives the external mux directly and changes only at slot boundaries, so the mux output has BLANK cycles to settle before capture.
- Blank phase, while `cnt` < BLANK: `an` all inactive, `seg_out`=SEG_OFF.
- Capture: at the rising edge ending the cycle with `cnt`==BLANK-1, `seg_reg`<=`seg_in` and `mask_reg`<=`digit_mask`.
- Show phase, while BLANK <= `cnt` <= DIV-1:
  - `seg_out`=`seg_reg`.
  - `an` asserts only bit `sel`, and only if `mask_reg[sel]`=1; otherwise `an` stays all inactive and `seg_out`=SEG_OFF.
  - Changes on `seg_in` or `digit_mask` during show have no effect until the next slot's capture.
- Slot end, `cnt`==DIV-1 and `enable`=1:
  - `cnt`<=0 and `sel`<=`sel`+1 (wraps 3->0).
  - Masked digits still consume their slot; `sel` never skips.
- `frame_tick`<=1 exactly when `cnt`==DIV-1, `sel`==3 and `enable`=1; otherwise 0. It is high for the single cycle after that edge.
- `enable`=0, sampled at an edge:
  - `cnt`<=0, `sel` holds, `frame_tick`<=0. The held `cnt`=0 keeps outputs blanked.
  - On re-enable, the current `sel` slot restarts from its blank phase with a fresh capture.
- Steady-state frame period: 4*DIV cycles. Per-digit duty: (DIV-BLANK)/(4*DIV).

Test Plan (DIV=8, BLANK=2, AN_ACTIVE_LOW=1, bench mux model: `seg_in`=D[`sel`], D0..D3 = 7'h01, 7'h02, 7'h04, 7'h08):
- Reset: `rst_n`=0 for 3 edges, `enable`=1, `digit_mask`=4'hF -> `sel`=0, `an`=4'b1111, `seg_out`=7'h7F, `frame_tick`=0 every cycle.
- Normal scan: release reset, `digit_mask`=4'hF -> each slot gives 2 cycles `an`=1111, then 6 cycles of:
  - 1110 with `seg_out`=7'h01,
  - then 1101 / 7'h02,
  - then 1011 / 7'h04,
  - then 0111 / 7'h08,
  - then the sequence repeats.
- Frame tick: `frame_tick` first high in cycle 32 after reset release, 1 cycle wide, then every 32 cycles. Never high while `enable`=0.
- Masking: `digit_mask`=4'b0101 -> `an` asserts only 1110 and 1011. Digit-1 and digit-3 slots show `an`=1111 and `seg_out`=7'h7F for all 8 cycles. `sel` still steps 0,1,2,3.
- Enable drop: `enable`=0 while `sel`=2, `cnt`=5 -> next cycle `an`=1111, `seg_out`=7'h7F, `sel`=2. Hold low 10 cycles, then `enable`=1 -> 2 blank cycles, then `an`=1011 with `seg_out`=7'h04 for 6 cycles.
- Stability and reset mid-scan:
  - Change D1 to 7'h7E during digit-1 show -> `seg_out` stays 7'h02 until that slot ends; the new value appears on the next digit-1 slot.
  - Assert `rst_n`=0 during a show phase -> at the next edge all outputs return to reset values.
